// File: rtl/psum_accum_drain.sv
// Lane-wise saturating psum accumulator over num_pass beats, then serial drain with optional ReLU.
// First word is valid the cycle after the last accepted beat; words hold while out_ready is low.
module psum_accum_drain #(
  parameter int NUM_OUT = 6,
  parameter int PSUM_W  = 16,
  parameter int ACC_W   = 24,
  parameter int PASS_W  = 4,
  parameter int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PASS_W-1:0]         num_pass,
  input  logic                      relu_en,
  input  logic                      in_valid,
  input  logic [NUM_OUT*PSUM_W-1:0] in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [ACC_W-1:0]          out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      sat_flag
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc      [NUM_OUT];
  logic signed [ACC_W-1:0] acc_nxt  [NUM_OUT];
  logic signed [PSUM_W-1:0] lane_v  [NUM_OUT];
  logic signed [ACC_W-1:0] ext_v    [NUM_OUT];
  logic signed [ACC_W:0]   sum_v    [NUM_OUT];
  logic [NUM_OUT-1:0]      lane_sat;
  logic [PASS_W-1:0]       pass_cnt;
  logic [PASS_W-1:0]       pass_tgt;
  logic                    relu_q;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    beat;
  logic                    last_beat;
  logic                    hs;

  function automatic logic [ACC_W-1:0] relu_fn(input logic signed [ACC_W-1:0] v,
                                               input logic en);
    return (en && v[ACC_W-1]) ? '0 : v;
  endfunction

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign out_idx   = idx;
  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (pass_cnt == pass_tgt - PASS_W'(1));
  assign hs        = out_valid & out_ready;
  assign idx_nxt   = idx + IDX_W'(1);

  // One extra guard bit per lane detects overflow of each individual addition.
  always_comb begin
    lane_sat = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      lane_v[i]  = in_data[i*PSUM_W +: PSUM_W];
      ext_v[i]   = ACC_W'(lane_v[i]);
      sum_v[i]   = (ACC_W+1)'(acc[i]) + (ACC_W+1)'(ext_v[i]);
      acc_nxt[i] = ext_v[i];
      if (pass_cnt != '0) begin
        if (sum_v[i][ACC_W] != sum_v[i][ACC_W-1]) begin
          lane_sat[i] = 1'b1;
          acc_nxt[i]  = sum_v[i][ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_nxt[i]  = sum_v[i][ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (last_beat) state_nxt = S_DRAIN;
      S_DRAIN: if (hs && out_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) acc[i] <= '0;
      pass_cnt <= '0;
      pass_tgt <= '0;
      relu_q   <= 1'b0;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pass_tgt <= (num_pass == '0) ? PASS_W'(1) : num_pass;
            relu_q   <= relu_en;
            sat_flag <= 1'b0;
            pass_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            for (int i = 0; i < NUM_OUT; i++) acc[i] <= acc_nxt[i];
            if (|lane_sat) sat_flag <= 1'b1;
            if (last_beat) begin
              // Lane 0 comes straight from the incoming sum so it is valid on DRAIN entry.
              idx      <= '0;
              out_data <= relu_fn(acc_nxt[0], relu_q);
              out_last <= (NUM_OUT == 1);
            end else begin
              pass_cnt <= pass_cnt + PASS_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (hs) begin
            if (out_last) begin
              done <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              out_data <= relu_fn(acc[idx_nxt], relu_q);
              out_last <= (idx_nxt == IDX_W'(NUM_OUT-1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_drain.sv
// Bench for psum_accum_drain: two instances (ACC_W 24 and 17) share stimulus, scoreboard per width.
module tb_psum_accum_drain;
  localparam int N    = 6;
  localparam int PW   = 16;
  localparam int AW_A = 24;
  localparam int AW_B = 17;
  localparam int PAW  = 4;
  localparam int IW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [PAW-1:0]  num_pass = '0;
  logic            relu_en = 1'b0;
  logic            in_valid = 1'b0;
  logic [N*PW-1:0] in_data = '0;
  logic            out_ready = 1'b1;

  logic            in_ready_a, out_valid_a, out_last_a, busy_a, done_a, sat_flag_a;
  logic [AW_A-1:0] out_data_a;
  logic [IW-1:0]   out_idx_a;
  logic            in_ready_b, out_valid_b, out_last_b, busy_b, done_b, sat_flag_b;
  logic [AW_B-1:0] out_data_b;
  logic [IW-1:0]   out_idx_b;

  always #5 clk = ~clk;

  psum_accum_drain #(.ACC_W(AW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_pass(num_pass), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_idx(out_idx_a),
    .out_last(out_last_a), .out_ready(out_ready), .busy(busy_a), .done(done_a),
    .sat_flag(sat_flag_a));

  psum_accum_drain #(.ACC_W(AW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_pass(num_pass), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_idx(out_idx_b),
    .out_last(out_last_b), .out_ready(out_ready), .busy(busy_b), .done(done_b),
    .sat_flag(sat_flag_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  longint lanes [N];
  longint bm_a [N];
  longint bm_b [N];
  int     bm_pass;
  int     bm_np;
  bit     bm_relu;
  bit     bm_sat_a, bm_sat_b;
  longint exp_a [$];
  longint exp_b [$];
  int     exp_i [$];
  bit     rdy_pat [16];
  bit     done_pend = 1'b0;

  function automatic longint satw(input longint v, input int w);
    longint mx = (longint'(1) <<< (w-1)) - 1;
    longint mn = -mx - 1;
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  // Scoreboard monitor: every valid cycle must show the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      done_pend = 1'b0;
    end else begin
      chk("done_a", done_a, done_pend);
      chk("done_b", done_b, done_pend);
      if (done_pend) chk("busy_at_done", busy_a, 0);
      done_pend = 1'b0;
      if (out_valid_a) begin
        chk("word_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          chk("valid_b", out_valid_b, 1);
          chk("data_a", $signed(out_data_a), exp_a[0]);
          chk("data_b", $signed(out_data_b), exp_b[0]);
          chk("idx_a", out_idx_a, exp_i[0]);
          chk("idx_b", out_idx_b, exp_i[0]);
          chk("last_a", out_last_a, exp_i[0] == N-1);
          if (out_ready) begin
            if (exp_i[0] == N-1) done_pend = 1'b1;
            void'(exp_a.pop_front());
            void'(exp_b.pop_front());
            void'(exp_i.pop_front());
          end
        end
      end
    end
  end

  task automatic do_start(input int np, input bit relu);
    start    = 1'b1;
    num_pass = PAW'(np);
    relu_en  = relu;
    bm_pass  = 0;
    bm_np    = (np == 0) ? 1 : np;
    bm_relu  = relu;
    bm_sat_a = 1'b0;
    bm_sat_b = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    num_pass = PAW'($urandom_range(0, 15));
    relu_en  = 1'(~relu);
    chk("start_in_ready", in_ready_a, 1);
    chk("start_busy", busy_a, 1);
    chk("start_sat_a_clr", sat_flag_a, 0);
    chk("start_sat_b_clr", sat_flag_b, 0);
  endtask

  task automatic send_beat(input int gap);
    longint s, t;
    for (int i = 0; i < N; i++) in_data[i*PW +: PW] = PW'(lanes[i]);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bm_pass == 0) begin
        bm_a[i] = lanes[i];
        bm_b[i] = lanes[i];
      end else begin
        s = bm_a[i] + lanes[i]; t = satw(s, AW_A); if (t != s) bm_sat_a = 1'b1; bm_a[i] = t;
        s = bm_b[i] + lanes[i]; t = satw(s, AW_B); if (t != s) bm_sat_b = 1'b1; bm_b[i] = t;
      end
    end
    bm_pass++;
    if (bm_pass == bm_np) begin
      for (int i = 0; i < N; i++) begin
        exp_a.push_back((bm_relu && bm_a[i] < 0) ? 0 : bm_a[i]);
        exp_b.push_back((bm_relu && bm_b[i] < 0) ? 0 : bm_b[i]);
        exp_i.push_back(i);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom};
    repeat (gap) begin
      chk("gap_no_out", out_valid_a, 0);
      chk("gap_in_ready", in_ready_a, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int pat_len, input int exp_cyc, input int start_at);
    int cyc = 0;
    chk("first_valid", out_valid_a, 1);
    chk("drain_in_ready", in_ready_a, 0);
    while (!done_a && cyc < 200) begin
      out_ready = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
      start     = (cyc == start_at);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("drain_cycles", cyc, exp_cyc);
    chk("busy_with_done", busy_a, 0);
    chk("sat_a", sat_flag_a, bm_sat_a);
    chk("sat_b", sat_flag_b, bm_sat_b);
    chk("queue_drained", exp_a.size(), 0);
    @(posedge clk); #1;
    chk("idle_after_done", busy_a, 0);
  endtask

  task automatic set_lanes(input longint l0, l1, l2, l3, l4, l5);
    lanes[0] = l0; lanes[1] = l1; lanes[2] = l2;
    lanes[3] = l3; lanes[4] = l4; lanes[5] = l5;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with random inputs: all outputs must read 0.
    #1 rst = 1'b1;
    repeat (4) begin
      start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      relu_en = 1'($urandom); num_pass = PAW'($urandom);
      in_data = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready_a, 0);
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_data", out_data_a, 0);
      chk("rst_out_idx", out_idx_a, 0);
      chk("rst_out_last", out_last_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_sat", sat_flag_a, 0);
    end
    start = 1'b0; out_ready = 1'b1; rst = 1'b0;
    @(posedge clk); #1;

    // Single pass, lanes 1..6, valid already high before start.
    set_lanes(1, 2, 3, 4, 5, 6);
    in_valid = 1'b1;
    do_start(1, 0);
    send_beat(0);
    drain(0, 6, -1);

    // Three passes with idle gaps.
    do_start(3, 0);
    send_beat(2);
    send_beat(2);
    send_beat(0);
    drain(0, 6, -1);

    // num_pass=0 behaves as 1; backpressure with a stray start mid-drain.
    rdy_pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    set_lanes(10, -20, 30, -40, 50, -60);
    do_start(0, 0);
    send_beat(0);
    drain(9, 9, 2);

    // Saturation: clamps in the 17-bit instance only.
    do_start(3, 0);
    set_lanes(32767, -32768, 32767, 0, 0, 0);
    send_beat(1);
    send_beat(0);
    set_lanes(32767, -32768, -32768, 0, 0, 0);
    send_beat(0);
    drain(0, 6, -1);

    // ReLU on output, then reset in the middle of the drain.
    do_start(1, 1);
    set_lanes(-5, 0, 7, -1, 32767, -32768);
    send_beat(0);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_idx", out_idx_a, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_out_valid_b", out_valid_b, 0);
    exp_a.delete(); exp_b.delete(); exp_i.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy_a, 0);

    // Fresh run after reset, mixed signs.
    do_start(2, 0);
    set_lanes(100, 200, 300, 400, 500, 600);
    send_beat(1);
    set_lanes(-1, -202, 3, -404, 5, -606);
    send_beat(0);
    drain(0, 6, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accum_drain.md
Name: psum_accum_drain

Overview:
- Parametrised partial-sum collector at the output edge of the PE array; successor to the fixed six-lane psum observation path.
- Per run, accepts `num_pass` beats of NUM_OUT signed psums, one beat per input-channel pass, and accumulates them lane-wise with saturation.
- Then drains the accumulated results serially over a valid/ready stream, with optional ReLU.
- Sits between the array's psum outputs and the ofmap writeback path.

Parameters:
- NUM_OUT, 6, number of psum lanes per beat.
- PSUM_W, 16, signed width of each incoming psum.
- ACC_W, 24, signed accumulator/output width; must be >= PSUM_W.
- PASS_W, 4, width of the pass-count input.
- IDX_W, $clog2(NUM_OUT) (min 1), width of the lane index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin run; sampled only in IDLE.
- num_pass  in  PASS_W  passes to accumulate; latched at start.
- relu_en  in  1  clamp negative results to 0 on output; latched at start.
- in_valid  in  1  psum beat valid.
- in_data  in  NUM_OUT*PSUM_W  lane i at bits [i*PSUM_W +: PSUM_W], signed.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- out_valid  out  1  drain word valid.
- out_data  out  ACC_W  accumulated lane value, signed.
- out_idx  out  IDX_W  lane index of out_data.
- out_last  out  1  high with the word for lane NUM_OUT-1.
- out_ready  in  1  downstream accept.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of drain.
- sat_flag  out  1  sticky: any lane saturated this run.

Behaviour:
Reset:
- Asserting rst at any time, including mid-ACCUM or mid-DRAIN, forces IDLE.
- All accumulators, pass counter and index are cleared to 0.
- in_ready, out_valid, out_data, out_idx, out_last, busy, done and sat_flag all go to 0.

States: IDLE, ACCUM, DRAIN.

IDLE:
- start=1 latches num_pass and relu_en, clears sat_flag and pass_cnt, then goes to ACCUM next cycle.
- num_pass=0 is latched as 1.
- start is ignored in any other state.

ACCUM:
- in_ready=1 for the whole state; in_valid gaps are allowed.
- Beat accepted with pass_cnt==0: acc[i] = sign-extend(lane i).
- Later accepted beats: acc[i] = sat(acc[i] + sext(lane i)).
- sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets sat_flag when a clamp occurs.
- The cycle after the beat where pass_cnt reaches num_pass-1: go to DRAIN, in_ready drops, idx=0.

DRAIN:
- out_valid=1, out_idx=idx, out_data=acc[idx] (0 if relu_en and negative), out_last=(idx==NUM_OUT-1).
- out_data, out_idx and out_last are registered outputs.
- They are held stable while out_valid&!out_ready.
- Each handshake increments idx.
- Handshake on the last word: next cycle out_valid=0, done=1 for one cycle, state=IDLE.

Timing:
- Latency: first out_valid in the cycle after the last accepted input beat.
- Zero-stall run with out_ready=1: done follows NUM_OUT cycles after the first out_valid.
- A start asserted in the done cycle is accepted; the state is already IDLE.

Other rules:
- In IDLE and DRAIN, in_data and in_valid are ignored.
- Accumulator contents are retained after done until the next run's first beat; they are not observable.
- Saturation is evaluated per addition, not at the end.
- ReLU is applied at output only; stored values are unchanged.

Test Plan:
1. Reset: hold rst with random inputs -> every output 0. Release, start with in_valid=1 the following cycles -> in_ready=1 the cycle after start.
2. Defaults, num_pass=1, beat lanes 1..6, out_ready=1 -> out_data 1,2,3,4,5,6 on idx 0..5; out_last only on idx 5; done pulse the next cycle; busy falls with done.
3. num_pass=3, three beats each lanes 1..6, in_valid low 2 cycles between beats -> outputs 3,6,9,12,15,18; no acceptance while in_valid=0; sat_flag=0.
4. Backpressure: out_ready pattern 1,0,0,1,0,1,1,1,1 -> each word held unchanged through stalls. Exactly 6 handshakes in order. start pulsed mid-drain is ignored.
5. Saturation, ACC_W=17, num_pass=3:
   - Lane0 32767 x3 -> 65535.
   - Lane1 -32768 x3 -> -65536.
   - Lane2 32767,32767,-32768 -> 32766.
   - sat_flag=1; it clears on the next start.
6. relu_en=1, lanes -5,0,7,-1,32767,-32768, num_pass=1 -> 0,0,7,0,32767,0. Then assert rst during idx 3 -> immediately out_valid=0, busy=0, no done. A fresh run then starts cleanly.
